// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM state type, screen timing constants and frame-memory address width.
package vga_pkg;
   typedef enum logic [1:0] {IDLE, READ, WAIT, CAPTURE} state_t;
   localparam int H_TOTAL   = 800;
   localparam int V_TOTAL   = 525;
   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;
   localparam int ADDR_W    = 17;
endpackage

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: maps a screen coordinate to a frame-memory word address plus an in-image flag.
module pixel_addr_gen
   import vga_pkg::*;
#(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int SCALE = 1
) (
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic              in_bounds
);
   logic [9:0] ix, iy;
   assign ix = x >> SCALE;
   assign iy = y >> SCALE;
   assign in_bounds = 32'(ix) < 32'(IMG_W) && 32'(iy) < 32'(IMG_H);
   // product formed at 32 bits; truncation only applies to addresses already known to be in the image
   assign addr = in_bounds ? ADDR_W'(32'(iy) * 32'(IMG_W) + 32'(ix)) : '0;
endmodule

// File: rtl/vga_pixel_responder.sv
// vga_pixel_responder: fetches one frame-memory pixel per request edge with a fixed latency of MEM_LATENCY+2.
module vga_pixel_responder
   import vga_pkg::*;
#(
   parameter int         IMG_W        = 320,
   parameter int         IMG_H        = 240,
   parameter int         SCALE        = 1,
   parameter int         MEM_LATENCY  = 2,
   parameter logic [3:0] BORDER_PIXEL = 4'h0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              new_pixel_request,
   input  logic [9:0]        new_pixel_x,
   input  logic [9:0]        new_pixel_y,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [3:0]        mem_rd_data,
   output logic [3:0]        grayscale_pixel,
   output logic              pixel_valid,
   output logic              busy,
   output logic [7:0]        overrun_count
);
   state_t            state, state_n;
   logic              req_q, armed, inb_q, inb_c, req_edge;
   logic [1:0]        wcnt;
   logic [ADDR_W-1:0] addr_c;

   pixel_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE)) u_addr (
      .x(new_pixel_x),
      .y(new_pixel_y),
      .addr(addr_c),
      .in_bounds(inb_c)
   );

   // armed stays low after reset until the request line is seen low, so a held level never fires
   assign req_edge  = new_pixel_request & ~req_q & armed;
   assign mem_rd_en = state == READ && inb_q;
   assign busy      = state != IDLE;

   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (req_edge ? READ : IDLE) :
                state == READ ? (MEM_LATENCY == 1 ? CAPTURE : WAIT) :
                state == WAIT ? (wcnt == 2'(MEM_LATENCY - 2) ? CAPTURE : WAIT) : IDLE;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state           <= IDLE;
         req_q           <= 1'b0;
         armed           <= 1'b0;
         inb_q           <= 1'b0;
         wcnt            <= 2'd0;
         mem_addr        <= '0;
         grayscale_pixel <= 4'h0;
         pixel_valid     <= 1'b0;
         overrun_count   <= 8'd0;
      end else begin
         state       <= state_n;
         req_q       <= new_pixel_request;
         armed       <= armed | ~new_pixel_request;
         pixel_valid <= state == CAPTURE;
         wcnt        <= state == WAIT ? wcnt + 2'd1 : 2'd0;
         if (state == IDLE && req_edge) begin
            mem_addr <= addr_c;
            inb_q    <= inb_c;
         end
         if (state == CAPTURE)
            grayscale_pixel <= inb_q ? mem_rd_data : BORDER_PIXEL;
         if (req_edge && state != IDLE && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
      end
endmodule

// File: tb/tb_vga_pixel_responder.sv
// tb_vga_pixel_responder: directed vector table plus hand-written overrun and reset sequences.
module tb_vga_pixel_responder;
   localparam int L = 2;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [3:0]  val;
      logic        rd;
      logic [16:0] addr;
      logic [3:0]  pix;
   } vec_t;

   logic        clk = 1'b0, reset_n = 1'b0, req = 1'b0;
   logic [9:0]  px = '0, py = '0;
   logic        mem_rd_en, pv, busy;
   logic [16:0] mem_addr, last_addr = '0;
   logic [3:0]  mem_rd_data, gp, mem_val = 4'h0;
   logic [7:0]  ovr;
   logic [L-1:0] pipe;
   int n_vec = 0, n_err = 0, fetches = 0, pulses = 0;
   vec_t vecs[8];

   vga_pixel_responder dut (
      .clk(clk),
      .reset_n(reset_n),
      .new_pixel_request(req),
      .new_pixel_x(px),
      .new_pixel_y(py),
      .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr),
      .mem_rd_data(mem_rd_data),
      .grayscale_pixel(gp),
      .pixel_valid(pv),
      .busy(busy),
      .overrun_count(ovr)
   );

   always #5 clk = ~clk;

   // frame memory: data is presented exactly L cycles after the read strobe
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) pipe <= '0;
      else pipe <= {pipe[L-2:0], mem_rd_en};
   assign mem_rd_data = pipe[L-1] ? mem_val : 4'h0;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         fetches   <= fetches + 1;
         last_addr <= mem_addr;
      end
      if (pv) pulses <= pulses + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int f0, p0;
      vecs[0] = '{10'd10,  10'd6,   4'hA, 1'b1, 17'd965,   4'hA};
      vecs[1] = '{10'd639, 10'd479, 4'h6, 1'b1, 17'd76799, 4'h6};
      vecs[2] = '{10'd640, 10'd0,   4'h9, 1'b0, 17'd0,     4'h0};
      vecs[3] = '{10'd0,   10'd0,   4'h5, 1'b1, 17'd0,     4'h5};
      vecs[4] = '{10'd100, 10'd480, 4'h7, 1'b0, 17'd0,     4'h0};
      vecs[5] = '{10'd2,   10'd478, 4'hF, 1'b1, 17'd76481, 4'hF};
      vecs[6] = '{10'd799, 10'd524, 4'h3, 1'b0, 17'd0,     4'h0};
      vecs[7] = '{10'd638, 10'd1,   4'hC, 1'b1, 17'd319,   4'hC};

      step(2);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pix", gp, 0);
      chk("rst_valid", pv, 0);
      chk("rst_ovr", ovr, 0);
      reset_n = 1'b1;
      step(2);

      foreach (vecs[i]) begin
         req = 1'b0;
         step(2);
         px = vecs[i].x; py = vecs[i].y; mem_val = vecs[i].val; req = 1'b1;
         chk("idle_before", busy, 0);
         step();
         req = 1'b0;
         chk("rd_en", mem_rd_en, vecs[i].rd);
         if (vecs[i].rd) chk("addr", mem_addr, vecs[i].addr);
         step(2);
         chk("valid_early", pv, 0);
         step();
         chk("valid", pv, 1);
         chk("pixel", gp, vecs[i].pix);
         step();
         chk("valid_once", pv, 0);
         chk("pixel_hold", gp, vecs[i].pix);
         chk("idle_after", busy, 0);
      end

      // held-high level, then a second edge exactly four cycles after the first
      req = 1'b0; step();
      f0 = fetches;
      px = 10'd10; py = 10'd6; mem_val = 4'hA; req = 1'b1;
      step(3);
      req = 1'b0;
      step();
      chk("held_valid1", pv, 1);
      chk("held_pix1", gp, 4'hA);
      px = 10'd2; py = 10'd478; mem_val = 4'h7; req = 1'b1;
      step(4);
      chk("held_valid2", pv, 1);
      chk("held_pix2", gp, 4'h7);
      chk("held_fetches", fetches - f0, 2);
      chk("held_ovr", ovr, 0);

      // second edge two cycles after the first is dropped
      req = 1'b0; step();
      px = 10'd10; py = 10'd6; mem_val = 4'hC; req = 1'b1;
      step(); req = 1'b0;
      step(); req = 1'b1; px = 10'd639; py = 10'd479;
      step(); req = 1'b0;
      chk("ovr_one", ovr, 1);
      step();
      chk("ovr_valid", pv, 1);
      chk("ovr_pix", gp, 4'hC);
      chk("ovr_addr", last_addr, 965);

      // edge coinciding with CAPTURE is an overrun, not a new fetch
      step();
      f0 = fetches;
      px = 10'd0; py = 10'd0; mem_val = 4'h3; req = 1'b1;
      step(); req = 1'b0;
      step(2); req = 1'b1;
      step();
      chk("cap_ovr", ovr, 2);
      chk("cap_busy", busy, 0);
      chk("cap_pix", gp, 4'h3);
      step();
      chk("cap_busy2", busy, 0);
      chk("cap_fetches", fetches - f0, 1);

      // toggling every cycle drives the overrun counter into saturation
      req = 1'b0; step();
      for (int i = 0; i < 1200; i++) begin
         req = ~req;
         step();
      end
      req = 1'b0;
      step(6);
      chk("ovr_sat", ovr, 255);

      // reset in WAIT aborts the fetch; the held level is ignored afterwards
      px = 10'd10; py = 10'd6; mem_val = 4'h9; req = 1'b1;
      step(2);
      chk("rw_busy", busy, 1);
      p0 = pulses;
      reset_n = 1'b0;
      #1;
      chk("rw_busy0", busy, 0);
      chk("rw_rd_en0", mem_rd_en, 0);
      chk("rw_addr0", mem_addr, 0);
      chk("rw_pix0", gp, 0);
      chk("rw_valid0", pv, 0);
      chk("rw_ovr0", ovr, 0);
      step(3);
      reset_n = 1'b1;
      f0 = fetches;
      step(8);
      chk("rw_no_pulse", pulses - p0, 0);
      chk("rw_no_fetch", fetches - f0, 0);
      chk("rw_idle", busy, 0);
      req = 1'b0; step();
      req = 1'b1; step();
      chk("rw_rearm", mem_rd_en, 1);
      chk("rw_addr", mem_addr, 965);
      step(3);
      chk("rw_valid", pv, 1);
      chk("rw_pix", gp, 4'h9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
